// File: rtl/color_pkg.sv
// color_pkg: shared constants, state encoding and helpers for the colour
// frame acquisition controller.
//   NUM_CH   - number of sensor channels
//   CH_W     - bits per channel sample (8b R, 8b G, 8b B)
//   FRAME_W  - published frame width, equals the SPI slave colour width
//   CH_SEL_W - width of the channel select bus
package color_pkg;

    localparam int NUM_CH   = 6;
    localparam int CH_W     = 24;
    localparam int FRAME_W  = NUM_CH * CH_W;
    localparam int CH_SEL_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_REL = 3'd3,
        PUBLISH  = 3'd4,
        HOLD     = 3'd5
    } ctrl_state_t;

    // One-hot mask for a channel index; out-of-range indices give zero.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_SEL_W-1:0] sel);
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == CH_SEL_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/color_frame_ctrl_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level.
// Both flops reset to 1 because the signal it carries (MCU chip select)
// idles high; a reset must not look like a chip-select falling edge.
//   clk     - destination clock
//   reset_n - asynchronous active-low reset
//   d       - asynchronous input
//   q       - synchronized output
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/color_frame_ctrl.sv
// color_frame_ctrl: acquires one colour frame from NUM_CH sensor channels
// over a four-phase req/ack handshake, publishes it to the SPI slave and
// holds it until the MCU completes one chip-select transaction.
//   clk, reset_n - system clock, asynchronous active-low reset
//   start        - level, acquire frames continuously while high
//   err_clr      - one-cycle pulse, clears err_flags
//   spi_cs_n     - MCU chip select (asynchronous, active low)
//   sample_ack   - sensor acknowledge
//   sample_data  - sensor data, valid while sample_ack is high
//   ch_sel       - channel being requested
//   sample_req   - request to the selected channel
//   color        - published frame, ch0 in the least significant slot
//   done         - frame valid and held for the SPI read
//   busy         - controller not idle
//   frame_count  - published-frame counter, wraps 255 -> 0
//   err_flags    - sticky per-channel timeout flags
module color_frame_ctrl
    import color_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                err_clr,
    input  logic                spi_cs_n,
    input  logic                sample_ack,
    input  logic [CH_W-1:0]     sample_data,
    output logic [CH_SEL_W-1:0] ch_sel,
    output logic                sample_req,
    output logic [FRAME_W-1:0]  color,
    output logic                done,
    output logic                busy,
    output logic [7:0]          frame_count,
    output logic [NUM_CH-1:0]   err_flags
);

    localparam int                  CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]    TMO_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [CH_SEL_W-1:0] LAST_CH = CH_SEL_W'(NUM_CH - 1);

    ctrl_state_t         state, state_nxt;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [FRAME_W-1:0]  staging;
    logic                cs_s, cs_prev, cs_fall_seen;
    logic                cs_fall, cs_rise;
    logic                tmo_hit, ack_tmo, rel_done, hold_exit;
    logic [NUM_CH-1:0]   err_set;

    sync2 u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_cs_n),
        .q       (cs_s)
    );

    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign tmo_hit   = (tmo_cnt == TMO_MAX);
    assign ack_tmo   = (state == WAIT_ACK) && !sample_ack && tmo_hit;
    assign rel_done  = (state == WAIT_REL) && (!sample_ack || tmo_hit);
    // Only a fall seen inside HOLD arms the exit, so a chip select that was
    // already low when the frame was published cannot release it.
    assign hold_exit = (state == HOLD) && cs_fall_seen && cs_rise;
    assign err_set   = ack_tmo ? ch_onehot(ch_sel) : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = REQ;
            REQ:      state_nxt = WAIT_ACK;
            WAIT_ACK: if (sample_ack || tmo_hit) state_nxt = WAIT_REL;
            WAIT_REL: if (rel_done) state_nxt = (ch_sel == LAST_CH) ? PUBLISH : REQ;
            PUBLISH:  state_nxt = HOLD;
            HOLD:     if (hold_exit) state_nxt = start ? REQ : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        sample_req = (state == REQ) || (state == WAIT_ACK);
        busy       = (state != IDLE);
    end

    // Channel sequencing, phase timeout and frame staging/publishing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_sel       <= '0;
            tmo_cnt      <= '0;
            staging      <= '0;
            color        <= '0;
            done         <= 1'b0;
            frame_count  <= 8'd0;
            cs_prev      <= 1'b1;
            cs_fall_seen <= 1'b0;
        end else begin
            cs_prev <= cs_s;
            unique case (state)
                IDLE: begin
                    if (start) ch_sel <= '0;
                end
                REQ: begin
                    tmo_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (sample_ack || tmo_hit) begin
                        // A timed-out channel publishes as zero, never stale data.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_sel == CH_SEL_W'(i))
                                staging[i*CH_W +: CH_W] <= sample_ack ? sample_data : '0;
                        end
                        tmo_cnt <= '0;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (rel_done) begin
                        if (ch_sel != LAST_CH) ch_sel <= ch_sel + 1'b1;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                PUBLISH: begin
                    color        <= staging;
                    done         <= 1'b1;
                    frame_count  <= frame_count + 8'd1;
                    cs_fall_seen <= 1'b0;
                end
                HOLD: begin
                    if (cs_fall) cs_fall_seen <= 1'b1;
                    if (hold_exit) begin
                        done   <= 1'b0;
                        ch_sel <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky timeout flags; a new timeout in the clearing cycle survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_flags <= '0;
        else          err_flags <= (err_clr ? '0 : err_flags) | err_set;
    end

endmodule

// File: tb/tb_color_frame_ctrl.sv
// tb_color_frame_ctrl: directed bench for color_frame_ctrl with a sensor
// model that builds the expected frame from the data it hands out, and a
// compare process that checks the published outputs every cycle.
module tb_color_frame_ctrl;
    import color_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n, start, err_clr, spi_cs_n, sample_ack;
    logic [CH_W-1:0]     sample_data;
    logic [CH_SEL_W-1:0] ch_sel;
    logic                sample_req, done, busy;
    logic [FRAME_W-1:0]  color;
    logic [7:0]          frame_count;
    logic [NUM_CH-1:0]   err_flags;

    int checks = 0;
    int errors = 0;

    // Sensor/model state
    int                  ack_dly = 2;
    int                  mute_ch = -1;
    logic [CH_W-1:0]     data_base = 24'hC00000;
    logic [CH_W-1:0]     slots [NUM_CH];
    logic [FRAME_W-1:0]  exp_color = '0, prev_color = '0;
    logic [7:0]          exp_count = 8'd0, prev_count = 8'd0;
    logic [NUM_CH-1:0]   exp_err = '0;
    bit                  pending = 1'b0;

    color_frame_ctrl #(.TIMEOUT_CYC(4095)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .err_clr     (err_clr),
        .spi_cs_n    (spi_cs_n),
        .sample_ack  (sample_ack),
        .sample_data (sample_data),
        .ch_sel      (ch_sel),
        .sample_req  (sample_req),
        .color       (color),
        .done        (done),
        .busy        (busy),
        .frame_count (frame_count),
        .err_flags   (err_flags)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [FRAME_W-1:0] act,
                       input logic [FRAME_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sensor model: acks ack_dly cycles after a request with data_base+ch,
    // releases when the request drops, records what each slot must hold.
    initial begin
        int  exp_ch;
        int  wait_cnt;
        bit  prev_req;
        logic [FRAME_W-1:0] nf;
        exp_ch = 0; wait_cnt = 0; prev_req = 1'b0;
        sample_ack = 1'b0; sample_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                exp_ch = 0; wait_cnt = 0; prev_req = 1'b0; sample_ack = 1'b0;
            end else begin
                if (sample_req && !prev_req) begin
                    chk("ch_sel_at_req", FRAME_W'(ch_sel), FRAME_W'(exp_ch));
                    wait_cnt = 0;
                end
                if (!sample_req && prev_req) begin
                    if (exp_ch == mute_ch) begin
                        slots[exp_ch] = '0;
                        exp_err[exp_ch] = 1'b1;
                    end
                    exp_ch++;
                    if (exp_ch == NUM_CH) begin
                        exp_ch = 0;
                        for (int c = 0; c < NUM_CH; c++) nf[c*CH_W +: CH_W] = slots[c];
                        prev_color = exp_color;
                        exp_color  = nf;
                        prev_count = exp_count;
                        exp_count  = exp_count + 8'd1;
                        pending    = 1'b1;
                    end
                end
                if (sample_ack && !sample_req) begin
                    sample_ack = 1'b0;
                end else if (sample_req && !sample_ack && exp_ch != mute_ch) begin
                    if (wait_cnt >= ack_dly) begin
                        sample_ack  = 1'b1;
                        sample_data = data_base + CH_W'(exp_ch);
                        slots[exp_ch] = sample_data;
                    end else begin
                        wait_cnt++;
                    end
                end
                prev_req = sample_req;
            end
            if (!sample_ack) sample_data = CH_W'($urandom);
        end
    end

    // Every-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (done && pending) pending = 1'b0;
            chk("color", color, pending ? prev_color : exp_color);
            chk("frame_count", FRAME_W'(frame_count), FRAME_W'(pending ? prev_count : exp_count));
            chk("err_flags", FRAME_W'(err_flags), FRAME_W'(exp_err));
            if (done) begin
                chk("req_in_hold", FRAME_W'(sample_req), '0);
                chk("busy_in_hold", FRAME_W'(busy), FRAME_W'(1));
            end
        end
    end

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin @(posedge clk); #1; n++; end
        chk(name, FRAME_W'(done), FRAME_W'(1));
    endtask

    task automatic wait_req_ch(input int ch, input int budget, input string name);
        int n = 0;
        while (!(sample_req && ch_sel == CH_SEL_W'(ch)) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk(name, FRAME_W'(sample_req), FRAME_W'(1));
    endtask

    // One chip-select transaction; lat = cycles from cs rise until done low.
    task automatic cs_txn(input int low_cyc, output int lat);
        spi_cs_n = 1'b0;
        repeat (low_cyc) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        lat = 0;
        while (done && lat < 10) begin @(posedge clk); #1; lat++; end
        if (done) lat = 99;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_color"}, color, '0);
        chk({tag, "_done"}, FRAME_W'(done), '0);
        chk({tag, "_req"}, FRAME_W'(sample_req), '0);
        chk({tag, "_ch_sel"}, FRAME_W'(ch_sel), '0);
        chk({tag, "_count"}, FRAME_W'(frame_count), '0);
        chk({tag, "_err"}, FRAME_W'(err_flags), '0);
        chk({tag, "_busy"}, FRAME_W'(busy), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, reqs;
        reset_n = 1'b0; start = 1'b0; err_clr = 1'b0; spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Nominal frame
        start = 1'b1;
        wait_done(200, "nominal_done");
        chk("nominal_color", color, 144'hC00005_C00004_C00003_C00002_C00001_C00000);
        chk("nominal_count", FRAME_W'(frame_count), FRAME_W'(1));
        chk("nominal_err", FRAME_W'(err_flags), '0);

        // HOLD handshake with a long chip-select low
        spi_cs_n = 1'b0;
        repeat (200) @(posedge clk);
        #1 chk("hold_done_cs_low", FRAME_W'(done), FRAME_W'(1));
        chk("hold_color", color, 144'hC00005_C00004_C00003_C00002_C00001_C00000);
        spi_cs_n = 1'b1;
        lat = 0;
        while (done && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("hold_release_lat_ok", FRAME_W'(lat >= 2 && lat <= 3), FRAME_W'(1));
        chk("next_req", FRAME_W'(sample_req), FRAME_W'(1));
        chk("next_ch0", FRAME_W'(ch_sel), '0);

        // Channel 3 never acknowledges
        mute_ch = 3;
        wait_done(6000, "tmo_done");
        mute_ch = -1;
        chk("tmo_color", color, 144'hC00005_C00004_000000_C00002_C00001_C00000);
        chk("tmo_err", FRAME_W'(err_flags), FRAME_W'(6'b001000));
        chk("tmo_count", FRAME_W'(frame_count), FRAME_W'(2));
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err = '0;
        chk("err_clr", FRAME_W'(err_flags), '0);
        cs_txn(4, lat);
        chk("tmo_release", FRAME_W'(lat <= 3), FRAME_W'(1));

        // Chip select already low when the frame is published
        spi_cs_n = 1'b0;
        wait_done(200, "cslow_done");
        chk("cslow_count", FRAME_W'(frame_count), FRAME_W'(3));
        repeat (5) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("cslow_rise_ignored", FRAME_W'(done), FRAME_W'(1));
        cs_txn(5, lat);
        chk("cslow_full_pulse", FRAME_W'(done), '0);

        // start dropped during channel 2
        wait_req_ch(2, 100, "reach_ch2");
        start = 1'b0;
        wait_done(200, "stop_done");
        chk("stop_count", FRAME_W'(frame_count), FRAME_W'(4));
        cs_txn(3, lat);
        chk("stop_released", FRAME_W'(done), '0);
        reqs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (sample_req) reqs++;
        end
        chk("idle_no_req", FRAME_W'(reqs), '0);
        chk("idle_busy", FRAME_W'(busy), '0);

        // Asynchronous reset while waiting on channel 4
        ack_dly = 3;
        start = 1'b1;
        wait_req_ch(4, 100, "reach_ch4");
        @(posedge clk);
        #3 reset_n = 1'b0;
        exp_color = '0; prev_color = '0; exp_count = 8'd0; prev_count = 8'd0;
        exp_err = '0; pending = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // 256 frames wrap the counter
        ack_dly = 0;
        for (int i = 1; i <= 256; i++) begin
            wait_done(400, "wrap_done");
            if (i == 255) chk("count_255", FRAME_W'(frame_count), FRAME_W'(255));
            if (i == 256) chk("count_wrap", FRAME_W'(frame_count), '0);
            data_base = CH_W'(i * 256);
            cs_txn(2, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
